// File: rtl/sr_latch_sync.sv
// Clocked set/reset flag with complementary outputs, selectable S=R=1
// policy, invalid-request status and change pulse.
module sr_latch_sync #(
  parameter logic RESET_Q        = 1'b0,
  parameter int   INVALID_POLICY = 2,
  parameter bit   STICKY_INVALID = 1'b0
) (
  input  logic clk,
  input  logic Clear,
  input  logic Enable,
  input  logic S,
  input  logic R,
  output logic Q,
  output logic Qbar,
  output logic invalid_seen,
  output logic changed
);

  localparam logic [1:0] POL = INVALID_POLICY[1:0];

  logic q_r;
  logic q_nx;
  logic inv_nx;
  logic inv_r;
  logic chg_r;

  always_comb begin
    q_nx   = q_r;
    inv_nx = 1'b0;
    if (Enable) begin
      unique case ({S, R})
        2'b10:   q_nx = 1'b1;
        2'b01:   q_nx = 1'b0;
        2'b11: begin
          inv_nx = 1'b1;
          unique case (POL)
            2'd0:    q_nx = 1'b1;
            2'd1:    q_nx = 1'b0;
            2'd3:    q_nx = ~q_r;
            default: q_nx = q_r;
          endcase
        end
        default: q_nx = q_r;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Clear) begin
    if (!Clear) begin
      q_r   <= RESET_Q;
      inv_r <= 1'b0;
      chg_r <= 1'b0;
    end else begin
      q_r   <= q_nx;
      chg_r <= q_nx ^ q_r;
      inv_r <= STICKY_INVALID ? (inv_r | inv_nx) : inv_nx;
    end
  end

  // Qbar comes from the same flop, so Q and Qbar can never agree
  assign Q            = q_r;
  assign Qbar         = ~q_r;
  assign invalid_seen = inv_r;
  assign changed      = chg_r;

endmodule

// File: tb/tb_sr_latch_sync.sv
// Randomized bench for sr_latch_sync: default-policy instance and a
// toggle/sticky instance checked against a rule-level model.
module tb_sr_latch_sync;

  logic clk;
  logic Clear;
  logic Enable;
  logic S;
  logic R;

  logic q0, qb0, inv0, chg0;
  logic q1, qb1, inv1, chg1;

  int total;
  int bad;

  // model state per instance: 0 = hold/pulse, 1 = toggle/sticky
  int pol [2] = '{2, 3};
  bit stk [2] = '{1'b0, 1'b1};
  bit mq  [2];
  bit minv[2];
  bit mchg[2];

  sr_latch_sync u_dut (
    .clk          (clk),
    .Clear        (Clear),
    .Enable       (Enable),
    .S            (S),
    .R            (R),
    .Q            (q0),
    .Qbar         (qb0),
    .invalid_seen (inv0),
    .changed      (chg0)
  );

  sr_latch_sync #(
    .RESET_Q        (1'b0),
    .INVALID_POLICY (3),
    .STICKY_INVALID (1'b1)
  ) u_tgl (
    .clk          (clk),
    .Clear        (Clear),
    .Enable       (Enable),
    .S            (S),
    .R            (R),
    .Q            (q1),
    .Qbar         (qb1),
    .invalid_seen (inv1),
    .changed      (chg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [3:0] got,
                     input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b (Q,Qbar,inv,chg)",
               tag, got, exp);
    end
  endtask

  function automatic logic [3:0] mexp(input int i);
    return {mq[i], ~mq[i], minv[i], mchg[i]};
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "/dflt"}, {q0, qb0, inv0, chg0}, mexp(0));
    chk({tag, "/tgl"},  {q1, qb1, inv1, chg1}, mexp(1));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i]   = 1'b0;
      minv[i] = 1'b0;
      mchg[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit old;
    bit inv;
    for (int i = 0; i < 2; i++) begin
      old = mq[i];
      inv = Enable && S && R;
      if (inv) begin
        if (pol[i] == 0) mq[i] = 1'b1;
        else if (pol[i] == 1) mq[i] = 1'b0;
        else if (pol[i] == 3) mq[i] = !old;
      end else if (Enable && S) begin
        mq[i] = 1'b1;
      end else if (Enable && R) begin
        mq[i] = 1'b0;
      end
      minv[i] = stk[i] ? (minv[i] | inv) : inv;
      mchg[i] = (mq[i] != old);
    end
  endtask

  // called at a negedge; returns at the following negedge
  task automatic cyc(input string tag, input bit e,
                     input bit s, input bit r);
    Enable = e;
    S      = s;
    R      = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic mid_clear(input string tag);
    Clear = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    Clear = 1'b1;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    Clear  = 1'b0;
    Enable = 1'bx;
    S      = 1'bx;
    R      = 1'bx;
    model_reset();
    #3;
    check_all("reset");

    @(negedge clk);
    Clear = 1'b1;
    cyc("dis00", 1'b0, 1'b0, 1'b0);
    cyc("dis10", 1'b0, 1'b1, 1'b0);
    cyc("dis01", 1'b0, 1'b0, 1'b1);
    cyc("dis11", 1'b0, 1'b1, 1'b1);
    cyc("set",   1'b1, 1'b1, 1'b0);
    cyc("hold",  1'b1, 1'b0, 1'b0);
    cyc("rst",   1'b1, 1'b0, 1'b1);
    cyc("inv1",  1'b1, 1'b1, 1'b1);
    cyc("inv2",  1'b1, 1'b1, 1'b1);
    cyc("inv3",  1'b1, 1'b1, 1'b1);
    cyc("post",  1'b1, 1'b0, 1'b0);
    cyc("set2",  1'b1, 1'b1, 1'b0);
    mid_clear("clr");
    cyc("rel",   1'b1, 1'b1, 1'b0);
    cyc("dishold", 1'b0, 1'b0, 1'b1);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 29) == 0)
        mid_clear("rclr");
      cyc("rand", ($urandom_range(0, 3) != 0),
          1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
